// File: rtl/soc1_cpu_mul_pkg.sv
// Shared constants for the sequential 32x32 multiplier: op encodings, FSM states,
// operand-half width and the partial-product alignment helper.
package soc1_cpu_mul_pkg;

    localparam int MUL_W = 16;
    localparam int ACC_W = 4 * MUL_W;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULXUU = 2'b01;
    localparam logic [1:0] MUL_OP_MULXSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULXSS = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ACC   = 3'd2,
        ST_FIX   = 3'd3,
        ST_DONE  = 3'd4
    } mul_state_e;

    // Bit offset of partial product k: one MUL_W step per "high half" operand used.
    function automatic int unsigned pp_shift(logic [1:0] idx);
        return (int'(idx[1]) + int'(idx[0])) * MUL_W;
    endfunction

endpackage

// File: rtl/soc1_cpu_mul_seq_cell.sv
// Shared W x W unsigned multiplier with a registered product; holds its value while ena is low.
module soc1_cpu_mul_seq_cell #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   p
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p <= '0;
        end else if (ena) begin
            p <= (2*W)'(a) * (2*W)'(b);
        end
    end

endmodule

// File: rtl/soc1_cpu_mul_seq.sv
// Multi-cycle 32x32 multiply sequencer: four 16x16 partial products through one cell,
// 64-bit accumulation, signed fix-up of the upper word, fixed 7-cycle accept-to-response.
module soc1_cpu_mul_seq #(
    parameter int MUL_W    = 16,
    parameter int RESULT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2*MUL_W-1:0]   req_src1,
    input  logic [2*MUL_W-1:0]   req_src2,
    input  logic [1:0]           req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RESULT_W-1:0]  rsp_result,
    output logic                 busy
);

    import soc1_cpu_mul_pkg::*;

    localparam int OP_W = 2 * MUL_W;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high
    // and flush is low (flush still lets a response in DONE be taken by rsp_ready).
    mul_state_e          state, state_nx;
    logic [1:0]          issue_cnt;
    logic [1:0]          acc_idx;
    logic                acc_en;
    logic                mul_ena;
    logic                accept;
    logic [OP_W-1:0]     src_a, src_b;
    logic [1:0]          op_q;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    pp_ext;
    logic [MUL_W-1:0]    mul_a, mul_b;
    logic [2*MUL_W-1:0]  mul_p;
    logic [OP_W-1:0]     corr_a, corr_b, hi_fix;
    logic [RESULT_W-1:0] result_q;

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign rsp_valid  = (state == ST_DONE);
    assign rsp_result = result_q;
    assign accept     = req_valid && req_ready && !flush;

    // k[1] picks the A half, k[0] picks the B half.
    assign mul_a = issue_cnt[1] ? src_a[OP_W-1:MUL_W] : src_a[MUL_W-1:0];
    assign mul_b = issue_cnt[0] ? src_b[OP_W-1:MUL_W] : src_b[MUL_W-1:0];

    soc1_cpu_mul_seq_cell #(.W(MUL_W)) u_cell (
        .clk   (clk),
        .reset (reset),
        .ena   (mul_ena),
        .a     (mul_a),
        .b     (mul_b),
        .p     (mul_p)
    );

    assign pp_ext = ACC_W'(mul_p) << pp_shift(acc_idx);

    // Two's-complement correction of the unsigned high word.
    assign corr_a = (op_q[1] && src_a[OP_W-1]) ? src_b : '0;
    assign corr_b = ((op_q == MUL_OP_MULXSS) && src_b[OP_W-1]) ? src_a : '0;
    assign hi_fix = acc[ACC_W-1:OP_W] - corr_a - corr_b;

    always_comb begin
        state_nx = state;
        mul_ena  = 1'b0;
        acc_en   = 1'b0;
        acc_idx  = issue_cnt - 2'd1;
        case (state)
            ST_IDLE:  if (req_valid) state_nx = ST_ISSUE;
            ST_ISSUE: begin
                mul_ena = 1'b1;
                // Product of the previous issue lands one cycle later.
                acc_en  = (issue_cnt != 2'd0);
                if (issue_cnt == 2'd3) state_nx = ST_ACC;
            end
            ST_ACC: begin
                acc_en   = 1'b1;
                acc_idx  = 2'd3;
                state_nx = ST_FIX;
            end
            ST_FIX:   state_nx = ST_DONE;
            ST_DONE:  if (rsp_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (flush) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            issue_cnt <= 2'd0;
            acc       <= '0;
            src_a     <= '0;
            src_b     <= '0;
            op_q      <= MUL_OP_MUL;
            result_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                src_a     <= req_src1;
                src_b     <= req_src2;
                op_q      <= req_op;
                acc       <= '0;
                issue_cnt <= 2'd0;
            end else begin
                if (state == ST_ISSUE) issue_cnt <= issue_cnt + 2'd1;
                if (acc_en) acc <= acc + pp_ext;
                if (state == ST_FIX) begin
                    result_q <= (op_q == MUL_OP_MUL) ? RESULT_W'(acc[OP_W-1:0])
                                                     : RESULT_W'(hi_fix);
                end
            end
        end
    end

endmodule

// File: tb/tb_soc1_cpu_mul_seq.sv
// Bench for soc1_cpu_mul_seq: directed latency/sign/backpressure/flush/reset cases and a
// randomized regression scored against a 64-bit arithmetic reference.
module tb_soc1_cpu_mul_seq;

    import soc1_cpu_mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_src1, req_src2;
    logic [1:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    soc1_cpu_mul_seq dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        sa = (op == MUL_OP_MULXUU || op == MUL_OP_MUL) ? $signed({32'b0, a})
                                                       : $signed({{32{a[31]}}, a});
        sb = (op == MUL_OP_MULXSS) ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
        p  = sa * sb;
        return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver tasks (all called at a falling edge) ----------------
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_wait", req_ready, 1'b1);
        req_src1  = a;
        req_src2  = b;
        req_op    = op;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input logic [31:0] exp);
        int lat;
        start_op(a, b, op);
        wait_rsp(lat);
        check({tag, "_lat"}, 64'(lat), 64'd7);
        check(tag, rsp_result, exp);
        consume();
        check({tag, "_ready_after"}, req_ready, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int seen;
        logic [31:0] exp_r;
        int in_flight, age, ops_done, n_flushed, cyc;
        logic [31:0] a, b;
        logic [1:0] op;

        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_src1 = '0; req_src2 = '0; req_op = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_result", rsp_result, 32'h0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // latency and basic results
        directed("basic_mul", 32'h0001_2345, 32'h0001_0000, MUL_OP_MUL, 32'h2345_0000);
        directed("basic_uu", 32'h0001_2345, 32'h0001_0000, MUL_OP_MULXUU, 32'h0000_0001);

        // sign handling
        directed("neg_mul", 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_OP_MUL, 32'h0000_0001);
        directed("neg_uu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_OP_MULXUU, 32'hFFFF_FFFE);
        directed("neg_su", 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_OP_MULXSU, 32'hFFFF_FFFF);
        directed("neg_ss", 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_OP_MULXSS, 32'h0000_0000);

        // backpressure
        exp_r = ref_mul(32'hDEAD_BEEF, 32'h0123_4567, MUL_OP_MULXSS);
        start_op(32'hDEAD_BEEF, 32'h0123_4567, MUL_OP_MULXSS);
        wait_rsp(lat);
        check("bp_lat", 64'(lat), 64'd7);
        for (int i = 0; i < 5; i++) begin
            check("bp_result", rsp_result, exp_r);
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        consume();
        check("bp_idle", req_ready, 1'b1);
        start_op(32'd3, 32'd5, MUL_OP_MUL);
        check("bp_next_accept", busy, 1'b1);
        wait_rsp(lat);
        check("bp_next_result", rsp_result, 32'd15);
        consume();

        // flush mid-operation at T+3
        start_op(32'h1234_5678, 32'h8765_4321, MUL_OP_MULXUU);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_req_ready", req_ready, 1'b1);
        check("flush_rsp_valid", rsp_valid, 1'b0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        check("flush_no_rsp", 64'(seen), 64'd0);
        directed("flush_next", 32'd7, 32'd6, MUL_OP_MUL, 32'h0000_002A);

        // asynchronous reset mid-operation at T+5
        start_op(32'h1234_5678, 32'h9ABC_DEF0, MUL_OP_MULXUU);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset_rsp_valid", rsp_valid, 1'b0);
        check("areset_busy", busy, 1'b0);
        check("areset_rsp_result", rsp_result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        directed("areset_next", 32'h8000_0000, 32'd2, MUL_OP_MULXSS, 32'hFFFF_FFFF);

        // randomized regression against the reference model
        in_flight = 0; age = 0; ops_done = 0; n_flushed = 0; cyc = 0;
        while (ops_done < 2000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (in_flight != 0) age++;
            check("rnd_busy", busy, in_flight != 0);
            check("rnd_req_ready", req_ready, in_flight == 0);
            check("rnd_rsp_valid", rsp_valid, (in_flight != 0) && (age >= 7));
            if (rsp_valid && exp_q.size() > 0) check("rnd_result", rsp_result, exp_q[0]);

            flush     = ($urandom_range(0, 39) == 0);
            rsp_ready = ($urandom_range(0, 1) == 1);
            req_valid = ($urandom_range(0, 9) < 7);
            a = rand_operand();
            b = rand_operand();
            op = 2'($urandom_range(0, 3));
            req_src1 = a; req_src2 = b; req_op = op;

            if (in_flight != 0 && rsp_valid && rsp_ready) begin
                void'(exp_q.pop_front());
                in_flight = 0;
                ops_done++;
            end else if (in_flight != 0 && flush) begin
                void'(exp_q.pop_front());
                in_flight = 0;
                n_flushed++;
            end else if (in_flight == 0 && req_valid && !flush) begin
                exp_q.push_back(ref_mul(a, b, op));
                in_flight = 1;
                age = 0;
            end
        end
        req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        check("rnd_ops_done", 64'(ops_done), 64'd2000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
